// File: rtl/mfp_uart_pkg.sv
// Shared types and helpers for the mfp UART blocks.
// Receiver state encoding, parity mode codes and the 3-way vote.
package mfp_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mfp_uart_baud_tick.sv
// Free-running oversample tick generator.
// One-cycle tick every clock_frequency/(baud_rate*oversample) clocks.
module mfp_uart_baud_tick #(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 9600,
  parameter int oversample      = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = clock_frequency / (baud_rate * oversample);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_err
    $error("mfp_uart_baud_tick: divisor is zero");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mfp_uart_receiver_cfg.sv
// Configurable oversampled UART receiver with majority voting.
// Reports framing, parity and line-break conditions.
module mfp_uart_receiver_cfg
  import mfp_uart_pkg::*;
#(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 9600,
  parameter int data_bits       = 8,
  parameter int parity_mode     = 0,
  parameter int stop_bits       = 1,
  parameter int oversample      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [data_bits-1:0] byte_data,
  output logic                 byte_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 break_detect
);

  localparam int SW = $clog2(oversample);
  localparam logic [SW-1:0] V0   = SW'(oversample/2 - 1);
  localparam logic [SW-1:0] V1   = SW'(oversample/2);
  localparam logic [SW-1:0] V2   = SW'(oversample/2 + 1);
  localparam logic [SW-1:0] SMAX = SW'(oversample - 1);

  if (data_bits < 5 || data_bits > 9 ||
      !(oversample == 8 || oversample == 16) ||
      !(stop_bits == 1 || stop_bits == 2) ||
      parity_mode < 0 || parity_mode > 2) begin : g_cfg_err
    $error("mfp_uart_receiver_cfg: illegal configuration");
  end

  logic tick;

  mfp_uart_baud_tick #(
    .clock_frequency(clock_frequency),
    .baud_rate      (baud_rate),
    .oversample     (oversample)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  uart_rx_state_t state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [SW-1:0] s_q, s_d;
  logic [1:0] smp_q, smp_d;
  logic [3:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [data_bits-1:0] shreg_q, shreg_d;
  logic par_err_q, par_err_d;
  logic frm_err_q, frm_err_d;
  logic stop_hi_q, stop_hi_d;
  logic [data_bits-1:0] data_q, data_d;
  logic rdy_q, rdy_d;
  logic fe_q, fe_d;
  logic pe_q, pe_d;

  logic vote_tick, wrap, voted, fe_now, hi_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      smp_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      stop_hi_q <= 1'b0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      s_q       <= s_d;
      smp_q     <= smp_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      stop_hi_q <= stop_hi_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = tick ? s_q + 1'b1 : s_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    stop_hi_d = stop_hi_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    fe_d      = fe_q;
    pe_d      = pe_q;

    vote_tick = tick && (s_q == V2);
    wrap      = tick && (s_q == SMAX);
    voted     = maj3(smp_q[0], smp_q[1], sync2_q);
    fe_now    = frm_err_q | ~voted;
    hi_now    = stop_hi_q | voted;

    if (tick && s_q == V0) smp_d[0] = sync2_q;
    if (tick && s_q == V1) smp_d[1] = sync2_q;

    unique case (state_q)
      ST_IDLE: begin
        s_d = '0;
        if (prev_q && !sync2_q) begin
          state_d   = ST_START;
          bit_d     = '0;
          stop_d    = 1'b0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          stop_hi_d = 1'b0;
        end
      end
      ST_START: begin
        if (vote_tick && voted) state_d = ST_IDLE;
        else if (wrap)          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_tick)
          shreg_d = {voted, shreg_q[data_bits-1:1]};
        if (wrap) begin
          if (bit_q == 4'(data_bits - 1))
            state_d = (parity_mode != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_d = bit_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (vote_tick)
          par_err_d = (^shreg_q) ^ voted ^ (parity_mode == PARITY_ODD);
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (vote_tick) begin
          frm_err_d = fe_now;
          stop_hi_d = hi_now;
          if (stop_q == 1'(stop_bits - 1)) begin
            rdy_d   = 1'b1;
            data_d  = shreg_q;
            fe_d    = fe_now;
            pe_d    = par_err_q;
            s_d     = '0;
            // an all-zero frame with no high stop bit is a held-low line
            state_d = (fe_now && !hi_now && shreg_q == '0) ? ST_BREAK
                                                           : ST_IDLE;
          end
        end else if (wrap) begin
          stop_d = 1'b1;
        end
      end
      ST_BREAK: begin
        if (!sync2_q)  s_d = '0;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_data     = data_q;
    byte_ready    = rdy_q;
    framing_error = fe_q;
    parity_error  = pe_q;
    break_detect  = (state_q == ST_BREAK);
  end

endmodule
